// File: rtl/axis_dc_restore_if.sv
// axis_dc_restore_if: minimal AXI-Stream channel (data, valid, ready).
interface axis_dc_restore_if #(parameter int W = 32) ();
  logic [W-1:0] tdata;
  logic tvalid;
  logic tready;
  modport master(output tdata, tvalid, input tready);
  modport slave(input tdata, tvalid, output tready);
endinterface

// File: rtl/axis_dc_restore.sv
// axis_dc_restore: adds a slew-limited programmable DC level to an LMS Q22 stream and emits 16-bit DAC samples.
module axis_dc_restore #(
  parameter int S_AXIS_DATA_WIDTH = 32,
  parameter int LMS_DATA_WIDTH = 26,
  parameter int LMS_Q_WIDTH = 22,
  parameter int M_AXIS_DATA_WIDTH = 16,
  parameter int SLEW_WIDTH = 16
) (
  input  logic aclk,
  input  logic aresetn,
  axis_dc_restore_if.slave s_axis,
  axis_dc_restore_if.master m_axis,
  input  logic [S_AXIS_DATA_WIDTH-1:0] dc_target,
  input  logic [SLEW_WIDTH-1:0] dc_slew,
  input  logic dc_load,
  input  logic dc_hold,
  input  logic sat_clear,
  output logic [S_AXIS_DATA_WIDTH-1:0] dc_current,
  output logic ramping,
  output logic [15:0] sat_count
);
  localparam int S = S_AXIS_DATA_WIDTH;
  localparam int L = LMS_DATA_WIDTH;
  localparam int M = M_AXIS_DATA_WIDTH;
  localparam int SH = LMS_Q_WIDTH - (M - 1);
  localparam logic signed [L+1:0] RND = (L+2)'(1) << (SH - 1);
  typedef enum logic {IDLE, RAMP} state_t;
  state_t state, state_nx;
  logic [1:0] cnt;
  logic tick, v1, v2, clip;
  logic signed [L-1:0] ac, dc, dc_nx, tgt, smp;
  logic signed [L:0] diff, adiff, slew_s, sum;
  logic signed [L+1:0] rnd;
  logic signed [L+1-SH:0] r;
  logic [M-1:0] out;
  // Out-of-range words saturate to the 26-bit extremes instead of wrapping.
  function automatic logic signed [L-1:0] clamp_in(input logic [S-1:0] x);
    return (&x[S-1:L-1] | ~|x[S-1:L-1]) ? x[L-1:0]
         : x[S-1] ? {1'b1, {(L-1){1'b0}}} : {1'b0, {(L-1){1'b1}}};
  endfunction
  assign tick = cnt == 2'd3;
  assign s_axis.tready = tick;
  assign dc_current = {{(S-L){dc[L-1]}}, dc};
  assign ramping = state == RAMP;
  always_comb begin
    smp = clamp_in(s_axis.tdata);
    tgt = clamp_in(dc_target);
    diff = {tgt[L-1], tgt} - {dc[L-1], dc};
    adiff = diff[L] ? -diff : diff;
    slew_s = {{(L+1-SLEW_WIDTH){1'b0}}, dc_slew};
    dc_nx = dc;
    state_nx = state;
    if (dc_load) begin
      dc_nx = tgt;
      state_nx = IDLE;
    end else if (!dc_hold) begin
      if (diff == '0) state_nx = IDLE;
      else if (dc_slew == '0 || adiff <= slew_s) begin
        dc_nx = tgt;
        state_nx = IDLE;
      end else begin
        dc_nx = diff[L] ? dc - slew_s[L-1:0] : dc + slew_s[L-1:0];
        state_nx = RAMP;
      end
    end
    rnd = {sum[L], sum} + RND;
    r = rnd[L+1:SH];
    clip = !(&r[L+1-SH:M-1] | ~|r[L+1-SH:M-1]);
    out = clip ? (r[L+1-SH] ? {1'b1, {(M-1){1'b0}}} : {1'b0, {(M-1){1'b1}}}) : r[M-1:0];
  end
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      cnt <= '0;
      ac <= '0;
      dc <= '0;
      state <= IDLE;
      v1 <= 1'b0;
      v2 <= 1'b0;
      sum <= '0;
      m_axis.tdata <= '0;
      m_axis.tvalid <= 1'b0;
      sat_count <= '0;
    end else begin
      cnt <= cnt + 2'd1;
      if (tick) begin
        if (s_axis.tvalid) ac <= smp;
        dc <= dc_nx;
        state <= state_nx;
      end
      v1 <= tick;
      v2 <= v1;
      sum <= {ac[L-1], ac} + {dc[L-1], dc};
      if (v2) m_axis.tdata <= out;
      m_axis.tvalid <= v2;
      sat_count <= sat_clear ? '0 : (v2 && clip && sat_count != 16'hFFFF) ? sat_count + 16'd1 : sat_count;
    end
  end
endmodule

// File: tb/tb_axis_dc_restore.sv
// tb_axis_dc_restore: directed stimulus checked each cycle against an arithmetic model of the DC restore path.
module tb_axis_dc_restore;
  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  logic [31:0] dc_target;
  logic [15:0] dc_slew;
  logic dc_load, dc_hold, sat_clear;
  logic [31:0] dc_current;
  logic ramping;
  logic [15:0] sat_count;
  always #5 aclk = ~aclk;
  axis_dc_restore_if #(.W(32)) s_axis ();
  axis_dc_restore_if #(.W(16)) m_axis ();
  assign m_axis.tready = 1'b1;
  axis_dc_restore dut (
    .aclk(aclk), .aresetn(aresetn), .s_axis(s_axis), .m_axis(m_axis),
    .dc_target(dc_target), .dc_slew(dc_slew), .dc_load(dc_load), .dc_hold(dc_hold),
    .sat_clear(sat_clear), .dc_current(dc_current), .ramping(ramping), .sat_count(sat_count)
  );
  typedef struct {int due; logic [15:0] v; bit clip;} out_t;
  out_t q[$];
  int errors = 0, checks = 0;
  int m_cnt, m_edge, m_sat;
  longint m_ac, m_dc;
  bit m_ramp, e_valid;
  logic [15:0] e_data;
  function automatic longint clamp26(input longint x);
    return x > 33554431 ? 33554431 : x < -33554432 ? -33554432 : x;
  endfunction
  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask
  task automatic model_reset();
    m_cnt = 0; m_edge = 0; m_sat = 0; m_ac = 0; m_dc = 0; m_ramp = 0;
    e_valid = 0; e_data = 0; q.delete();
  endtask
  task automatic model_edge();
    longint tgt, diff, ad, sum, r;
    out_t o;
    m_edge++;
    e_valid = 0;
    if (q.size() > 0 && q[0].due == m_edge) begin
      o = q.pop_front();
      e_valid = 1;
      e_data = o.v;
      if (o.clip && m_sat < 65535) m_sat++;
    end
    if (sat_clear) m_sat = 0;
    if (m_cnt == 3) begin
      if (s_axis.tvalid) m_ac = clamp26(longint'($signed(s_axis.tdata)));
      tgt = clamp26(longint'($signed(dc_target)));
      diff = tgt - m_dc;
      ad = diff < 0 ? -diff : diff;
      if (dc_load) begin m_dc = tgt; m_ramp = 0; end
      else if (!dc_hold) begin
        if (diff == 0) m_ramp = 0;
        else if (dc_slew == 0 || ad <= longint'(dc_slew)) begin m_dc = tgt; m_ramp = 0; end
        else begin m_dc += diff > 0 ? longint'(dc_slew) : -longint'(dc_slew); m_ramp = 1; end
      end
      sum = m_ac + m_dc;
      r = (sum + 64) >>> 7;
      o.due = m_edge + 2;
      o.clip = r > 32767 || r < -32768;
      o.v = 16'(r > 32767 ? 32767 : r < -32768 ? -32768 : r);
      q.push_back(o);
    end
    m_cnt = (m_cnt + 1) % 4;
  endtask
  task automatic cyc(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge aclk);
      if (aresetn) model_edge(); else model_reset();
      #1;
      check("tready", s_axis.tready, aresetn && m_cnt == 3);
      check("tvalid", m_axis.tvalid, e_valid);
      check("tdata", m_axis.tdata, e_data);
      check("dc_current", longint'($signed(dc_current)), m_dc);
      check("ramping", ramping, m_ramp);
      check("sat_count", sat_count, m_sat);
    end
  endtask
  initial begin
    model_reset();
    s_axis.tvalid = 1; s_axis.tdata = 32'h0000_8000;
    dc_target = 0; dc_slew = 0; dc_load = 0; dc_hold = 0; sat_clear = 0;
    cyc(3);
    aresetn = 1;
    cyc(3);
    check("first_tready", s_axis.tready, 1);
    cyc(3);
    check("first_out_valid", m_axis.tvalid, 1);
    check("first_out_data", m_axis.tdata, 16'h0100);
    cyc(1);
    check("valid_pulse_end", m_axis.tvalid, 0);
    s_axis.tdata = 0; dc_target = 32'h0040_0000; dc_slew = 16'h1000;
    cyc(200);
    check("ramp_active", ramping, 1);
    cyc(4100);
    check("ramp_done_dc", dc_current, 32'h0040_0000);
    check("ramp_done_idle", ramping, 0);
    check("ramp_done_out", m_axis.tdata, 16'h7FFF);
    sat_clear = 1; cyc(1); sat_clear = 0;
    check("sat_clear1", sat_count, 0);
    dc_load = 1; dc_target = 0; cyc(4); dc_load = 0;
    check("load_zero", dc_current, 0);
    dc_target = 32'h0010_0000; dc_slew = 16'h3000;
    cyc(160);
    dc_target = 0;
    cyc(200);
    check("reverse_end", dc_current, 0);
    check("reverse_idle", ramping, 0);
    dc_target = 32'h0010_0000; dc_slew = 16'h1000;
    cyc(40);
    dc_hold = 1;
    cyc(40);
    dc_hold = 0;
    cyc(40);
    dc_hold = 1; dc_load = 1; dc_target = 32'h0020_0000;
    cyc(4);
    check("hold_load", dc_current, 32'h0020_0000);
    dc_hold = 0; dc_target = 0; cyc(4); dc_load = 0;
    s_axis.tdata = 32'h7FFF_FFFF;
    cyc(8);
    check("clip_pos", m_axis.tdata, 16'h7FFF);
    s_axis.tdata = 32'h8000_0000;
    cyc(8);
    check("clip_neg", m_axis.tdata, 16'h8000);
    sat_clear = 1; cyc(1); sat_clear = 0;
    check("sat_clear2", sat_count, 0);
    s_axis.tdata = 0; dc_target = 32'h0040_0000; dc_slew = 16'h0100;
    cyc(100);
    #2 aresetn = 0;
    #1 model_reset();
    check("rst_dc", dc_current, 0);
    check("rst_ramp", ramping, 0);
    check("rst_tvalid", m_axis.tvalid, 0);
    check("rst_tdata", m_axis.tdata, 0);
    check("rst_sat", sat_count, 0);
    cyc(3);
    aresetn = 1;
    cyc(200);
    check("ramp_after_rst", ramping, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
